// File: rtl/cmac_tx_axis_arb.sv
`default_nettype none
// ============================================================================
// Module   : cmac_tx_axis_arb
// Brief    : Packet-atomic round-robin merge of NUM_CH AXIS sources onto the
//            CMAC TX AXIS port, with a one-stage output register slice.
//            Define CMAC_TX_ARB_PKT_CNT_EN to build per-channel packet counters.
// Revision : 1.0 - initial release
// ============================================================================
module cmac_tx_axis_arb #(
    parameter  int NUM_CH = 2,
    parameter  int DATA_W = 512,
    parameter  int CNT_W  = 32,
    localparam int KEEP_W = DATA_W / 8,
    localparam int CH_W   = $clog2(NUM_CH)
) (
    input  logic                     clk,
    input  logic                     reset,

    input  logic [NUM_CH-1:0]        s_axis_tvalid,
    output logic [NUM_CH-1:0]        s_axis_tready,
    input  logic [NUM_CH*DATA_W-1:0] s_axis_tdata,
    input  logic [NUM_CH*KEEP_W-1:0] s_axis_tkeep,
    input  logic [NUM_CH-1:0]        s_axis_tlast,
    input  logic [NUM_CH-1:0]        s_axis_tuser,

    output logic                     m_axis_tvalid,
    input  logic                     m_axis_tready,
    output logic [DATA_W-1:0]        m_axis_tdata,
    output logic [KEEP_W-1:0]        m_axis_tkeep,
    output logic                     m_axis_tlast,
    output logic                     m_axis_tuser,

    input  logic [NUM_CH-1:0]        ch_enable,
    output logic [CH_W-1:0]          active_ch,
    output logic                     busy,
    output logic [NUM_CH*CNT_W-1:0]  pkt_cnt,
    input  logic                     cnt_clear
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_PASS = 1'b1
    } state_t;

    state_t              state_q;
    logic [CH_W-1:0]     active_ch_q;
    logic [CH_W-1:0]     last_ch_q;

    logic                m_tvalid_q;
    logic [DATA_W-1:0]   m_tdata_q;
    logic [KEEP_W-1:0]   m_tkeep_q;
    logic                m_tlast_q;
    logic                m_tuser_q;

    logic                w_out_rdy;
    logic                w_sel_valid;
    logic                w_sel_last;
    logic                w_sel_user;
    logic [DATA_W-1:0]   w_sel_data;
    logic [KEEP_W-1:0]   w_sel_keep;
    logic                w_accept;
    logic                w_accept_last;
    logic [NUM_CH-1:0]   w_tready;

    logic                w_grant_found;
    logic [CH_W-1:0]     w_grant_ch;
    logic [CH_W-1:0]     w_scan_idx;

    // The slot can take a new beat when empty or when it is draining this cycle.
    assign w_out_rdy     = !m_tvalid_q || m_axis_tready;

    assign w_sel_valid   = s_axis_tvalid[active_ch_q];
    assign w_sel_last    = s_axis_tlast[active_ch_q];
    assign w_sel_user    = s_axis_tuser[active_ch_q];
    assign w_sel_data    = s_axis_tdata[int'(active_ch_q)*DATA_W +: DATA_W];
    assign w_sel_keep    = s_axis_tkeep[int'(active_ch_q)*KEEP_W +: KEEP_W];

    assign w_accept      = (state_q == ST_PASS) && w_out_rdy && w_sel_valid;
    assign w_accept_last = w_accept && w_sel_last;

    always_comb begin
        w_tready = '0;
        if (state_q == ST_PASS) begin
            w_tready[active_ch_q] = w_out_rdy;
        end
    end

    assign s_axis_tready = w_tready;

    // Rotating search starting one past the last granted channel.
    always_comb begin
        w_grant_found = 1'b0;
        w_grant_ch    = '0;
        w_scan_idx    = '0;
        for (int k = 1; k <= NUM_CH; k++) begin
            w_scan_idx = CH_W'((int'(last_ch_q) + k) % NUM_CH);
            if (!w_grant_found && s_axis_tvalid[w_scan_idx] && ch_enable[w_scan_idx]) begin
                w_grant_found = 1'b1;
                w_grant_ch    = w_scan_idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            active_ch_q <= '0;
            last_ch_q   <= CH_W'(NUM_CH - 1);
            m_tvalid_q  <= 1'b0;
            m_tdata_q   <= '0;
            m_tkeep_q   <= '0;
            m_tlast_q   <= 1'b0;
            m_tuser_q   <= 1'b0;
        end else begin
            if (w_accept) begin
                m_tvalid_q <= 1'b1;
                m_tdata_q  <= w_sel_data;
                m_tkeep_q  <= w_sel_keep;
                m_tlast_q  <= w_sel_last;
                m_tuser_q  <= w_sel_user;
            end else if (m_axis_tready) begin
                m_tvalid_q <= 1'b0;
            end

            case (state_q)
                ST_IDLE: begin
                    if (w_grant_found) begin
                        active_ch_q <= w_grant_ch;
                        last_ch_q   <= w_grant_ch;
                        state_q     <= ST_PASS;
                    end
                end
                ST_PASS: begin
                    if (w_accept_last) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign m_axis_tvalid = m_tvalid_q;
    assign m_axis_tdata  = m_tdata_q;
    assign m_axis_tkeep  = m_tkeep_q;
    assign m_axis_tlast  = m_tlast_q;
    assign m_axis_tuser  = m_tuser_q;
    assign active_ch     = active_ch_q;
    assign busy          = (state_q == ST_PASS);

`ifdef CMAC_TX_ARB_PKT_CNT_EN
    for (genvar g = 0; g < NUM_CH; g++) begin : g_pkt_cnt
        logic [CNT_W-1:0] cnt_q;
        logic [CNT_W-1:0] cnt_d;

        // Clear takes priority over a completing packet in the same cycle.
        always_comb begin
            cnt_d = cnt_q;
            if (cnt_clear) begin
                cnt_d = '0;
            end else if (w_accept_last && (active_ch_q == CH_W'(g))) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_d;
            end
        end

        assign pkt_cnt[g*CNT_W +: CNT_W] = cnt_q;
    end
`else
    logic unused_cnt_clear;
    assign unused_cnt_clear = cnt_clear;
    assign pkt_cnt          = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cmac_tx_axis_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_cmac_tx_axis_arb
// Brief    : Directed self-checking bench for cmac_tx_axis_arb (NUM_CH=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_cmac_tx_axis_arb;

    localparam int NUM_CH = 4;
    localparam int DATA_W = 512;
    localparam int KEEP_W = DATA_W / 8;
    localparam int CNT_W  = 4;
    localparam int CH_W   = $clog2(NUM_CH);
    localparam int DEPTH  = 256;
    localparam int OBS_D  = 1024;

    logic                     clk;
    logic                     reset;
    logic [NUM_CH-1:0]        s_axis_tvalid;
    logic [NUM_CH-1:0]        s_axis_tready;
    logic [NUM_CH*DATA_W-1:0] s_axis_tdata;
    logic [NUM_CH*KEEP_W-1:0] s_axis_tkeep;
    logic [NUM_CH-1:0]        s_axis_tlast;
    logic [NUM_CH-1:0]        s_axis_tuser;
    logic                     m_axis_tvalid;
    logic                     m_axis_tready;
    logic [DATA_W-1:0]        m_axis_tdata;
    logic [KEEP_W-1:0]        m_axis_tkeep;
    logic                     m_axis_tlast;
    logic                     m_axis_tuser;
    logic [NUM_CH-1:0]        ch_enable;
    logic [CH_W-1:0]          active_ch;
    logic                     busy;
    logic [NUM_CH*CNT_W-1:0]  pkt_cnt;
    logic                     cnt_clear;

    cmac_tx_axis_arb #(
        .NUM_CH (NUM_CH),
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) u_dut (
        .clk           (clk),
        .reset         (reset),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tkeep  (s_axis_tkeep),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tuser  (s_axis_tuser),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tuser  (m_axis_tuser),
        .ch_enable     (ch_enable),
        .active_ch     (active_ch),
        .busy          (busy),
        .pkt_cnt       (pkt_cnt),
        .cnt_clear     (cnt_clear)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // Beat tag: channel, packet number, beat index; replicated across tdata.
    function automatic logic [63:0] mk(input int ch, input int pkt, input int b);
        return {8'(ch), 24'(pkt), 32'(b)};
    endfunction

    // Per-channel source queues
    logic [63:0]     q_tag  [NUM_CH][DEPTH];
    logic [KEEP_W-1:0] q_keep [NUM_CH][DEPTH];
    logic            q_last [NUM_CH][DEPTH];
    int              wr_p   [NUM_CH];
    int              rd_p   [NUM_CH];
    int              hs_cnt [NUM_CH];
    logic            pop    [NUM_CH];

    task automatic push_pkt(input int ch, input int pkt, input int nb, input logic [KEEP_W-1:0] last_keep);
        for (int b = 0; b < nb; b++) begin
            q_tag[ch][wr_p[ch] + b]  = mk(ch, pkt, b);
            q_keep[ch][wr_p[ch] + b] = (b == nb - 1) ? last_keep : '1;
            q_last[ch][wr_p[ch] + b] = (b == nb - 1);
        end
        wr_p[ch] = wr_p[ch] + nb;
    endtask

    initial begin : p_drive
        s_axis_tvalid = '0;
        s_axis_tdata  = '0;
        s_axis_tkeep  = '0;
        s_axis_tlast  = '0;
        s_axis_tuser  = '0;
        forever begin
            @(negedge clk);
            for (int c = 0; c < NUM_CH; c++) begin
                pop[c] = 1'b0;
                if (reset) begin
                    rd_p[c] = wr_p[c];
                end else if (s_axis_tvalid[c] && s_axis_tready[c]) begin
                    pop[c]    = 1'b1;
                    hs_cnt[c] = hs_cnt[c] + 1;
                end
            end
            @(posedge clk);
            #1;
            for (int c = 0; c < NUM_CH; c++) begin
                if (pop[c] && rd_p[c] < wr_p[c]) rd_p[c] = rd_p[c] + 1;
                if (rd_p[c] < wr_p[c]) begin
                    s_axis_tvalid[c]                  = 1'b1;
                    s_axis_tdata[c*DATA_W +: DATA_W]  = {8{q_tag[c][rd_p[c]]}};
                    s_axis_tkeep[c*KEEP_W +: KEEP_W]  = q_keep[c][rd_p[c]];
                    s_axis_tlast[c]                   = q_last[c][rd_p[c]];
                    s_axis_tuser[c]                   = q_tag[c][rd_p[c]][0];
                end else begin
                    s_axis_tvalid[c] = 1'b0;
                end
            end
        end
    end

    // Output monitor: log accepted beats and verify stall stability
    logic [63:0]       obs_tag  [OBS_D];
    logic [KEEP_W-1:0] obs_keep [OBS_D];
    logic              obs_last [OBS_D];
    logic              obs_user [OBS_D];
    int                obs_n = 0;
    logic              p_stall = 1'b0;
    logic [DATA_W-1:0] p_data;
    logic [KEEP_W+1:0] p_ctl;

    initial begin : p_mon
        forever begin
            @(negedge clk);
            if (p_stall) begin
                check_eq("hold_valid", 64'(m_axis_tvalid), 64'd1);
                check_eq("hold_data", 64'(m_axis_tdata == p_data), 64'd1);
                check_eq("hold_ctl", 64'({m_axis_tlast, m_axis_tuser, m_axis_tkeep} == p_ctl), 64'd1);
            end
            if (m_axis_tvalid && m_axis_tready && obs_n < OBS_D) begin
                obs_tag[obs_n]  = m_axis_tdata[63:0];
                obs_keep[obs_n] = m_axis_tkeep;
                obs_last[obs_n] = m_axis_tlast;
                obs_user[obs_n] = m_axis_tuser;
                obs_n           = obs_n + 1;
                check_eq("data_rep", 64'(m_axis_tdata == {8{m_axis_tdata[63:0]}}), 64'd1);
            end
            p_stall = !reset && m_axis_tvalid && !m_axis_tready;
            p_data  = m_axis_tdata;
            p_ctl   = {m_axis_tlast, m_axis_tuser, m_axis_tkeep};
        end
    end

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic wait_obs(input int n, input int budget, input string tag);
        int c = 0;
        while (obs_n < n && c < budget) begin
            @(posedge clk);
            #1;
            c++;
        end
        check_eq(tag, 64'(obs_n >= n), 64'd1);
    endtask

    task automatic wait_hs(input int ch, input int n, input int budget, input string tag);
        int c = 0;
        while (hs_cnt[ch] < n && c < budget) begin
            @(posedge clk);
            #1;
            c++;
        end
        check_eq(tag, 64'(hs_cnt[ch] >= n), 64'd1);
    endtask

    initial begin : p_watchdog
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin : p_test
        int base, nbad, h0, sn;
        int vc, bc, mc;
        int per_ch [NUM_CH];

        reset         = 1'b1;
        m_axis_tready = 1'b1;
        ch_enable     = '1;
        cnt_clear     = 1'b0;

        // Reset state
        do_reset();
        check_eq("rst_tready", 64'(s_axis_tready), 64'd0);
        check_eq("rst_mvalid", 64'(m_axis_tvalid), 64'd0);
        check_eq("rst_mdata", 64'(|m_axis_tdata), 64'd0);
        check_eq("rst_mkeep", 64'(m_axis_tkeep), 64'd0);
        check_eq("rst_mlast_user", 64'({m_axis_tlast, m_axis_tuser}), 64'd0);
        check_eq("rst_busy", 64'(busy), 64'd0);
        check_eq("rst_active", 64'(active_ch), 64'd0);
        check_eq("rst_pktcnt", 64'(pkt_cnt), 64'd0);

        // ch0 9-beat (522 B) and ch1 2-beat packets, valid together
        base = obs_n;
        push_pkt(0, 0, 9, 64'h3FF);
        push_pkt(1, 0, 2, '1);
        vc = -1; bc = -1; mc = -1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (vc < 0 && s_axis_tvalid[0]) vc = c;
            if (bc < 0 && busy) bc = c;
            if (mc < 0 && m_axis_tvalid) mc = c;
        end
        check_eq("arb_latency", 64'(bc - vc), 64'd1);
        check_eq("out_latency", 64'(mc - bc), 64'd1);
        wait_obs(base + 11, 100, "A_timeout");
        nbad = 0;
        for (int i = 0; i < 11; i++) begin
            if (obs_tag[base + i] !== ((i < 9) ? mk(0, 0, i) : mk(1, 0, i - 9))) nbad++;
        end
        check_eq("A_order", 64'(nbad), 64'd0);
        check_eq("A_last_keep", 64'(obs_keep[base + 8]), 64'h3FF);
        check_eq("A_last_flag", 64'({obs_last[base + 7], obs_last[base + 8]}), 64'b01);
        check_eq("A_user", 64'({obs_user[base + 0], obs_user[base + 1]}), 64'b01);

        // Round robin, 4 channels x 25 single-beat packets
        do_reset();
        base = obs_n;
        for (int p = 0; p < 25; p++) begin
            for (int c = 0; c < NUM_CH; c++) push_pkt(c, p, 1, '1);
        end
        wait_obs(base + 100, 500, "RR_timeout");
        for (int i = 0; i < 4; i++) check_eq("RR_first_grants", 64'(obs_tag[base + i][63:56]), 64'(i));
        nbad = 0;
        for (int c = 0; c < NUM_CH; c++) per_ch[c] = 0;
        for (int i = 0; i < 100; i++) begin
            if (obs_tag[base + i] !== mk(i % 4, i / 4, 0)) nbad++;
            per_ch[obs_tag[base + i][57:56]]++;
        end
        check_eq("RR_order", 64'(nbad), 64'd0);
        for (int c = 0; c < NUM_CH; c++) check_eq("RR_per_ch", 64'(per_ch[c]), 64'd25);

        // Output stall of 5 cycles mid-packet
        do_reset();
        base = obs_n;
        h0   = hs_cnt[0];
        push_pkt(0, 1, 8, '1);
        wait_obs(base + 3, 50, "ST_start_timeout");
        m_axis_tready = 1'b0;
        sn = obs_n;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check_eq("ST_src_ready", 64'(s_axis_tready), 64'd0);
            @(posedge clk);
            #1;
        end
        check_eq("ST_no_output", 64'(obs_n), 64'(sn));
        m_axis_tready = 1'b1;
        wait_obs(base + 8, 50, "ST_timeout");
        repeat (5) @(posedge clk);
        #1;
        check_eq("ST_count", 64'(obs_n - base), 64'd8);
        check_eq("ST_src_beats", 64'(hs_cnt[0] - h0), 64'd8);
        nbad = 0;
        for (int i = 0; i < 8; i++) if (obs_tag[base + i] !== mk(0, 1, i)) nbad++;
        check_eq("ST_order", 64'(nbad), 64'd0);

        // ch_enable[0] dropped on beat 3 of a 6-beat packet
        do_reset();
        base = obs_n;
        h0   = hs_cnt[0];
        push_pkt(0, 2, 6, '1);
        push_pkt(0, 3, 1, '1);
        push_pkt(1, 2, 1, '1);
        push_pkt(1, 3, 1, '1);
        wait_hs(0, h0 + 3, 50, "EN_beat3_timeout");
        ch_enable[0] = 1'b0;
        wait_obs(base + 8, 100, "EN_timeout");
        repeat (10) @(posedge clk);
        #1;
        check_eq("EN_blocked", 64'(obs_n - base), 64'd8);
        check_eq("EN_idle", 64'(busy), 64'd0);
        nbad = 0;
        for (int i = 0; i < 6; i++) if (obs_tag[base + i] !== mk(0, 2, i)) nbad++;
        if (obs_tag[base + 6] !== mk(1, 2, 0)) nbad++;
        if (obs_tag[base + 7] !== mk(1, 3, 0)) nbad++;
        check_eq("EN_order", 64'(nbad), 64'd0);
        ch_enable[0] = 1'b1;
        wait_obs(base + 9, 20, "EN_reen_timeout");
        check_eq("EN_reenabled", obs_tag[base + 8], mk(0, 3, 0));

        // Reset on beat 4 of an 8-beat ch0 packet
        do_reset();
        h0 = hs_cnt[0];
        push_pkt(0, 4, 8, '1);
        wait_hs(0, h0 + 4, 50, "RM_beat4_timeout");
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_eq("RM_mvalid", 64'(m_axis_tvalid), 64'd0);
        check_eq("RM_busy", 64'(busy), 64'd0);
        check_eq("RM_tready", 64'(s_axis_tready), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        base = obs_n;
        push_pkt(1, 5, 1, '1);
        push_pkt(0, 9, 1, '1);
        wait_obs(base + 2, 50, "RM_timeout");
        check_eq("RM_first_grant", obs_tag[base], mk(0, 9, 0));
        check_eq("RM_second_grant", obs_tag[base + 1], mk(1, 5, 0));

        // Packet counters: 17 ch1 packets with a 4-bit counter
        do_reset();
        base = obs_n;
        for (int p = 0; p < 17; p++) push_pkt(1, 10 + p, 1, '1);
        wait_obs(base + 17, 100, "CNT_timeout");
        repeat (2) @(posedge clk);
        #1;
`ifdef CMAC_TX_ARB_PKT_CNT_EN
        check_eq("CNT_wrap_ch1", 64'(pkt_cnt[1*CNT_W +: CNT_W]), 64'd1);
        check_eq("CNT_ch0", 64'(pkt_cnt[0 +: CNT_W]), 64'd0);
`else
        check_eq("CNT_tied_zero", 64'(pkt_cnt), 64'd0);
`endif
        // Clear coinciding with a tlast beat
        cnt_clear = 1'b1;
        h0 = hs_cnt[0];
        push_pkt(0, 30, 1, '1);
        wait_hs(0, h0 + 1, 50, "CLR_timeout");
        cnt_clear = 1'b0;
        @(negedge clk);
        check_eq("CLR_wins", 64'(pkt_cnt), 64'd0);
        base = obs_n;
        push_pkt(0, 31, 1, '1);
        wait_obs(base + 1, 50, "CNT2_timeout");
        repeat (2) @(posedge clk);
        #1;
`ifdef CMAC_TX_ARB_PKT_CNT_EN
        check_eq("CNT_after_clear", 64'(pkt_cnt), 64'd1);
`else
        check_eq("CNT_after_clear", 64'(pkt_cnt), 64'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cmac_tx_axis_arb.md
# cmac_tx_axis_arb

Packet-atomic, round-robin arbiter that merges `NUM_CH` 512-bit AXI4-Stream sources (ERNIC TX, packet generator, future DMA engines) into the single CMAC TX AXIS port. It replaces the fixed point-to-point hookup between one source and the CMAC. Grants are held from first beat to `tlast`, so frames never interleave. Output is a one-stage register slice in the `txusrclk2` domain.

## Interface
- `NUM_CH`, 2: number of input channels, 2..8.
- `DATA_W`, 512: tdata width; `KEEP_W = DATA_W/8`.
- `CNT_W`, 32: per-channel packet counter width; used only with `CMAC_TX_ARB_PKT_CNT_EN`.
- `CH_W`, `$clog2(NUM_CH)`: channel index width (derived, not overridable).

Ports:
- `clk` in 1: CMAC TX user clock (`txusrclk2`).
- `reset` in 1: synchronous, active-high (driven from `usr_tx_reset`).
- `s_axis_tvalid` in NUM_CH: per-channel valid.
- `s_axis_tready` out NUM_CH: per-channel ready.
- `s_axis_tdata` in NUM_CH*DATA_W: channel i occupies bits [i*DATA_W +: DATA_W].
- `s_axis_tkeep` in NUM_CH*KEEP_W: byte enables, packed as for tdata.
- `s_axis_tlast` in NUM_CH: end of packet.
- `s_axis_tuser` in NUM_CH: error flag, forwarded unchanged.
- `m_axis_tvalid`, `m_axis_tready`, `m_axis_tdata`, `m_axis_tkeep`, `m_axis_tlast`, `m_axis_tuser` out/in/out/out/out/out, widths 1/1/DATA_W/KEEP_W/1/1: to CMAC `tx_axis_*`.
- `ch_enable` in NUM_CH: channel eligible for new grants.
- `active_ch` out CH_W: channel currently granted.
- `busy` out 1: grant held (state PASS).
- `pkt_cnt` out NUM_CH*CNT_W: completed packets per channel (macro only).
- `cnt_clear` in 1: synchronous clear of all `pkt_cnt` (macro only).

## Operation
- Two states: IDLE and PASS.
- IDLE: candidates are channels with `s_axis_tvalid[i] & ch_enable[i]`. The grant goes to the first candidate found searching upward from `last_ch+1` (mod NUM_CH). If there is a candidate, latch `active_ch`, set `last_ch = active_ch`, go to PASS. With no candidate, stay in IDLE.
- PASS:
  - `s_axis_tready[active_ch] = !m_axis_tvalid | m_axis_tready`; all other readies are 0.
  - On each accepted beat, load data, keep, last and user into the output register.
  - An accepted beat with `tlast=1` returns the block to IDLE in the next cycle.
- In IDLE all `s_axis_tready` are 0. The output register drains independently whenever `m_axis_tready=1`.
- `ch_enable` deasserted mid-packet has no effect on the current packet. It only blocks future grants.
- tkeep and tuser pass through unchecked. Zero-length or non-contiguous keep is the source's responsibility.
- Reset mid-packet:
  - The partial frame is abandoned.
  - Sources must restart frames after reset; CMAC sees truncation via its own underflow handling.

## Timing
- Reset values:
  - all `s_axis_tready` = 0;
  - `m_axis_tvalid` = 0; `m_axis_tdata/tkeep/tlast/tuser` = 0;
  - `active_ch` = 0; `busy` = 0; `last_ch` = NUM_CH-1, so channel 0 wins the first arbitration;
  - `pkt_cnt` = 0.
- Arbitration takes 1 cycle: a valid seen in IDLE at cycle t gives `busy` and a ready at t+1.
- Input-to-output latency is 1 cycle: a beat accepted at t appears on `m_axis_*` at t+1.
- Throughput is 1 beat per cycle within a packet. There is one dead input cycle between packets, because IDLE is always visited.
- `m_axis_*` holds stable while `m_axis_tvalid & !m_axis_tready`. `m_axis_tvalid` is never withdrawn without a handshake.
- Ready toward sources depends combinationally on `m_axis_tready`. There is no combinational path from `s_axis_tvalid` to `s_axis_tready`.

## Configuration
- `CMAC_TX_ARB_PKT_CNT_EN` defined:
  - `pkt_cnt[i]` increments on each accepted `tlast` beat of channel i;
  - wraps modulo 2^CNT_W;
  - `cnt_clear` wins over a simultaneous increment, giving 0 on the next cycle.
- Undefined: `pkt_cnt` is tied to 0, `cnt_clear` is ignored, and no counter flops are built.

## Test plan
- NUM_CH=2, ch0 sends a 9-beat packet (522 B, last tkeep=0x3FF) and ch1 a 2-beat packet, both valid at once after reset:
  - ch0 is output first, beats 1..9 in order;
  - then ch1 with no interleave;
  - `m_axis_tkeep` on the last ch0 beat = 0x3FF.
- All channels continuously valid with 1-beat packets, NUM_CH=4 → grant sequence 0,1,2,3,0…; each channel receives 25 of 100 packets.
- `m_axis_tready` held low 5 cycles mid-packet → `m_axis_*` held stable; exactly one beat is accepted from the source per ready cycle; no beat is lost or duplicated.
- `ch_enable[0]` dropped on beat 3 of a 6-beat ch0 packet → ch0 packet completes, then only ch1 is granted until re-enabled.
- `reset` asserted on beat 4 of an 8-beat packet → next cycle: `m_axis_tvalid=0`, `busy=0`, readies 0; the next arbitration grants ch0.
- With macro, CNT_W=4:
  - 17 ch1 packets → `pkt_cnt[1]=1` (wrapped);
  - `cnt_clear` coinciding with a tlast → `pkt_cnt=0`.

  Without macro → `pkt_cnt` is always 0.
